// File: rtl/impl_pkg.sv
// Shared types and constants for the implied-literal queue arbiter.
// Holds the literal-width helper, the controller state encoding and the queue depth.
package impl_pkg;

  localparam int QUEUE_DEPTH = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // One extra bit above the literal index carries the polarity.
  function automatic int lit_w(input int literals);
    return $clog2(literals) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotation: grants the first requester at or
// above i_ptr (wrapping modulo NUM_REQ); the pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin : search
    logic w_found;
    int   w_idx;
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/impl_queue_arbiter.sv
// Write-port arbiter, head handshake and pop-based flush sequencer for the
// 4-entry implied-literal queue. Optional duplicate filter: IMPL_DUP_FILTER_EN.
module impl_queue_arbiter
  import impl_pkg::*;
#(
  parameter  int LITERALS = 8,
  parameter  int NUM_REQ  = 4,
  parameter  int CNT_W    = 8,
  localparam int LIT_W    = lit_w(LITERALS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LIT_W-1:0] i_req_lit,
  output logic [NUM_REQ-1:0]       o_gnt,
  input  logic                     i_flush,
  output logic                     o_fifo_wren,
  output logic [LIT_W-1:0]         o_fifo_din,
  output logic                     o_fifo_ren,
  input  logic [LIT_W-1:0]         i_fifo_dout,
  input  logic                     i_fifo_full,
  input  logic                     i_fifo_empty,
  output logic                     o_prop_valid,
  output logic [LIT_W-1:0]         o_prop_lit,
  input  logic                     i_prop_ready,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [NUM_REQ-1:0] w_rr_gnt;
  logic               w_run;
  logic               w_arb_en;
  logic               w_grant;
  logic               w_write;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req (i_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_rr_gnt)
  );

  // Full is sampled before any same-cycle pop, so a full queue never takes a grant.
  assign w_run    = (r_state == ST_RUN);
  assign w_arb_en = w_run & ~i_flush & ~i_fifo_full & ~i_rst;
  assign o_gnt    = w_arb_en ? w_rr_gnt : '0;
  assign w_grant  = |o_gnt;

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_rr_gnt[i]) w_gnt_idx = PTR_W'(i);
    end
  end

  assign o_fifo_din = i_req_lit[w_gnt_idx*LIT_W +: LIT_W];

`ifdef IMPL_DUP_FILTER_EN
  logic [LIT_W-1:0] r_last_lit;
  logic             r_last_vld;
  logic             w_dup;

  assign w_dup   = r_last_vld & (o_fifo_din == r_last_lit);
  assign w_write = w_grant & ~w_dup;

  // A repeat of the last written literal is acknowledged but not re-queued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_lit <= '0;
      r_last_vld <= 1'b0;
    end else if (w_run & i_flush) begin
      r_last_vld <= 1'b0;
    end else if (w_write) begin
      r_last_lit <= o_fifo_din;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_write = w_grant;
`endif

  assign o_fifo_wren  = w_write;
  assign o_prop_lit   = i_fifo_dout;
  assign o_prop_valid = w_run & ~i_fifo_empty & ~i_flush;
  assign o_fifo_ren   = w_run ? (o_prop_valid & i_prop_ready) : ~i_fifo_empty;
  assign o_busy       = (r_state == ST_FLUSH);
  assign o_drop_cnt   = r_drop_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (i_flush) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (i_fifo_empty & ~i_flush) w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (!w_run && o_fifo_ren && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_impl_queue_arbiter.sv
// Self-checking bench for impl_queue_arbiter: directed scenarios plus a randomized
// run against a behavioural model; a queue model stands in for the 4-entry FIFO.
module tb_impl_queue_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_lit = '0;
  logic [3:0]  gnt;
  logic        flush = 1'b0;
  logic        fifo_wren;
  logic [3:0]  fifo_din;
  logic        fifo_ren;
  logic [3:0]  fifo_dout = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        prop_valid;
  logic [3:0]  prop_lit;
  logic        prop_ready = 1'b0;
  logic        busy;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] q[$];

  int m_ptr, m_drop, m_flushing, m_lastv;
  logic [3:0] m_last;

  impl_queue_arbiter #(.LITERALS(8), .NUM_REQ(4), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_req_lit    (req_lit),
    .o_gnt        (gnt),
    .i_flush      (flush),
    .o_fifo_wren  (fifo_wren),
    .o_fifo_din   (fifo_din),
    .o_fifo_ren   (fifo_ren),
    .i_fifo_dout  (fifo_dout),
    .i_fifo_full  (fifo_full),
    .i_fifo_empty (fifo_empty),
    .o_prop_valid (prop_valid),
    .o_prop_lit   (prop_lit),
    .i_prop_ready (prop_ready),
    .o_busy       (busy),
    .o_drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: pop before push so a full queue can pop and push in one cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      if (fifo_ren && q.size() > 0) void'(q.pop_front());
      if (fifo_wren && q.size() < 4) q.push_back(fifo_din);
    end
    fifo_empty <= (q.size() == 0);
    fifo_full  <= (q.size() == 4);
    fifo_dout  <= (q.size() > 0) ? q[0] : 4'h0;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drain();
    @(negedge clk);
    req = '0; flush = 1'b0; prop_ready = 1'b1;
    for (int i = 0; i < 20 && !fifo_empty; i++) @(negedge clk);
    n_checks++;
    if (fifo_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drain: fifo_empty got %b required 1", fifo_empty);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; req_lit = 16'h4321; flush = 1'b0; prop_ready = 1'b0;
    #12;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b required 0000", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_drop: got %0d required 0", drop_cnt); end
    n_checks++; if (fifo_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wren: got %b required 0", fifo_wren); end
    n_checks++; if (prop_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pvalid: got %b required 0", prop_valid); end
    @(negedge clk);
    rst = 1'b0; req = '0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    logic [3:0] exp_d;
    @(negedge clk);
    req = 4'b1111; req_lit = 16'hDCBA; prop_ready = 1'b1; flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      exp_d = req_lit[(k % 4) * 4 +: 4];
      n_checks++; if (gnt !== exp_g) begin n_fail++; $display("[TB] FAIL fair_gnt%0d: got %b required %b", k, gnt, exp_g); end
      n_checks++; if (fifo_din !== exp_d) begin n_fail++; $display("[TB] FAIL fair_din%0d: got %h required %h", k, fifo_din, exp_d); end
      @(negedge clk);
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    drain();
    prop_ready = 1'b0; req = 4'b0100; req_lit = 16'h0500;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (gnt !== ((k < 4) ? 4'b0100 : 4'b0000)) begin
        n_fail++; $display("[TB] FAIL bp_gnt%0d: got %b required %b", k, gnt, (k < 4) ? 4'b0100 : 4'b0000);
      end
      n_checks++;
      if (fifo_wren !== (k < 4)) begin n_fail++; $display("[TB] FAIL bp_wren%0d: got %b required %b", k, fifo_wren, k < 4); end
      @(negedge clk);
    end
    prop_ready = 1'b1;
    #1;
    n_checks++; if (fifo_ren !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ren: got %b required 1", fifo_ren); end
    n_checks++; if (prop_lit !== 4'h5) begin n_fail++; $display("[TB] FAIL bp_head: got %h required 5", prop_lit); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_fullgnt: got %b required 0000", gnt); end
    @(negedge clk);
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("[TB] FAIL bp_regrant: got %b required 0100", gnt); end
  endtask

  task automatic test_flush_data();
    int nbusy, nren;
    logic [7:0] d0;
    drain();
    prop_ready = 1'b0; req = 4'b0001; req_lit = 16'h0007;
    repeat (3) @(negedge clk);
    req = 4'b1111; flush = 1'b1; d0 = drop_cnt;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL fl_req_gnt: got %b required 0000", gnt); end
    n_checks++; if (prop_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_req_pv: got %b required 0", prop_valid); end
    n_checks++; if (fifo_ren !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_req_ren: got %b required 0", fifo_ren); end
    @(negedge clk);
    flush = 1'b0;
    nbusy = 0; nren = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!busy) break;
      nbusy++;
      if (fifo_ren) nren++;
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL fl_gnt: got %b required 0000", gnt); end
      n_checks++; if (prop_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_pv: got %b required 0", prop_valid); end
      @(negedge clk);
    end
    n_checks++; if (nbusy != 4) begin n_fail++; $display("[TB] FAIL fl_busy_len: got %0d required 4", nbusy); end
    n_checks++; if (nren != 3) begin n_fail++; $display("[TB] FAIL fl_pops: got %0d required 3", nren); end
    n_checks++; if (drop_cnt !== d0 + 8'd3) begin n_fail++; $display("[TB] FAIL fl_drop: got %0d required %0d", drop_cnt, d0 + 8'd3); end
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("[TB] FAIL fl_resume: got %b required 0010", gnt); end
  endtask

  task automatic test_flush_empty();
    int nbusy;
    logic [7:0] d0;
    drain();
    flush = 1'b1; d0 = drop_cnt;
    @(negedge clk);
    flush = 1'b0; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!busy) break;
      nbusy++;
      @(negedge clk);
    end
    n_checks++; if (nbusy != 1) begin n_fail++; $display("[TB] FAIL fe_busy_len: got %0d required 1", nbusy); end
    n_checks++; if (drop_cnt !== d0) begin n_fail++; $display("[TB] FAIL fe_drop: got %0d required %0d", drop_cnt, d0); end
  endtask

  task automatic test_async_reset();
    drain();
    prop_ready = 1'b0; req = 4'b0001; req_lit = 16'h0009;
    repeat (2) @(negedge clk);
    req = 4'b1111; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_pre_busy: got %b required 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_busy: got %b required 0", busy); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("[TB] FAIL ar_gnt: got %b required 0000", gnt); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL ar_drop: got %0d required 0", drop_cnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("[TB] FAIL ar_ptr: got %b required 0001", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_run: got %b required 0", busy); end
  endtask

  task automatic test_dup_filter();
    int ngnt, nwr, exp_wr;
    logic [3:0] lits [3];
    lits[0] = 4'h3; lits[1] = 4'h3; lits[2] = 4'h4;
    drain();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    prop_ready = 1'b0; ngnt = 0; nwr = 0;
    for (int k = 0; k < 3; k++) begin
      req = 4'b0001; req_lit = {12'h000, lits[k]};
      #1;
      if (gnt == 4'b0001) ngnt++;
      if (fifo_wren) nwr++;
      @(negedge clk);
    end
    req = '0;
`ifdef IMPL_DUP_FILTER_EN
    exp_wr = 2;
`else
    exp_wr = 3;
`endif
    n_checks++; if (ngnt != 3) begin n_fail++; $display("[TB] FAIL dup_grants: got %0d required 3", ngnt); end
    n_checks++; if (nwr != exp_wr) begin n_fail++; $display("[TB] FAIL dup_writes: got %0d required %0d", nwr, exp_wr); end
    n_checks++; if (q.size() != exp_wr) begin n_fail++; $display("[TB] FAIL dup_qsize: got %0d required %0d", q.size(), exp_wr); end
  endtask

  task automatic test_random();
    int sz, win;
    logic [3:0] e_g, e_din;
    logic e_wr, e_pv, e_ren, e_busy;
    @(negedge clk);
    rst = 1'b1; req = '0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_drop = 0; m_flushing = 0; m_lastv = 0; m_last = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      req = 4'($urandom); req_lit = 16'($urandom);
      flush = ($urandom_range(0, 11) == 0);
      prop_ready = ($urandom_range(0, 1) == 1);
      #1;
      sz = q.size();
      e_g = '0; e_din = '0; e_wr = 1'b0; e_pv = 1'b0; e_ren = 1'b0; win = -1;
      e_busy = (m_flushing != 0);
      if (m_flushing == 0) begin
        if (!flush && sz < 4) begin
          for (int k = 0; k < 4; k++) begin
            if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
          end
        end
        if (win >= 0) begin
          e_g = 4'b0001 << win;
          e_din = req_lit[win * 4 +: 4];
          e_wr = 1'b1;
`ifdef IMPL_DUP_FILTER_EN
          if (m_lastv != 0 && e_din == m_last) e_wr = 1'b0;
`endif
        end
        e_pv = (sz > 0) && !flush;
        e_ren = e_pv && prop_ready;
      end else begin
        e_ren = (sz > 0);
      end
      n_checks++; if (gnt !== e_g) begin n_fail++; $display("[TB] FAIL rnd_gnt@%0d: got %b required %b", n, gnt, e_g); end
      n_checks++; if (fifo_wren !== e_wr) begin n_fail++; $display("[TB] FAIL rnd_wren@%0d: got %b required %b", n, fifo_wren, e_wr); end
      if (win >= 0) begin
        n_checks++; if (fifo_din !== e_din) begin n_fail++; $display("[TB] FAIL rnd_din@%0d: got %h required %h", n, fifo_din, e_din); end
      end
      n_checks++; if (prop_valid !== e_pv) begin n_fail++; $display("[TB] FAIL rnd_pv@%0d: got %b required %b", n, prop_valid, e_pv); end
      n_checks++; if (fifo_ren !== e_ren) begin n_fail++; $display("[TB] FAIL rnd_ren@%0d: got %b required %b", n, fifo_ren, e_ren); end
      n_checks++; if (busy !== e_busy) begin n_fail++; $display("[TB] FAIL rnd_busy@%0d: got %b required %b", n, busy, e_busy); end
      n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("[TB] FAIL rnd_drop@%0d: got %0d required %0d", n, drop_cnt, m_drop); end
      if (m_flushing == 0) begin
        if (win >= 0) begin
          m_ptr = (win + 1) % 4;
          if (e_wr) begin m_last = e_din; m_lastv = 1; end
        end
        if (flush) begin m_flushing = 1; m_lastv = 0; end
      end else begin
        if (sz > 0 && m_drop < 255) m_drop++;
        if (sz == 0 && !flush) m_flushing = 0;
      end
    end
    req = '0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_flush_data();
    test_flush_empty();
    test_async_reset();
    test_dup_filter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/impl_queue_arbiter.md
Name: impl_queue_arbiter

Overview:
- Controller and arbiter for the 4-entry implied-literal queue in the CDCL propagation path.
- Shares the queue's single write port among NUM_REQ clause-evaluation requesters using round-robin arbitration.
- Presents the queue head to the propagation unit with a valid/ready handshake.
- On conflict or backtrack, sequences a flush that discards all queued literals by popping them, since the queue has no clear input.

Parameters:
- LITERALS, 8, number of literals; LIT_W = $clog2(LITERALS)+1 bits per literal word.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- CNT_W, 8, width of the saturating discard counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-requester push request.
- req_lit  in  NUM_REQ*LIT_W  packed literals; requester i occupies bits [i*LIT_W +: LIT_W].
- gnt  out  NUM_REQ  one-hot grant; the literal is accepted this cycle.
- flush  in  1  conflict/backtrack pulse; starts a flush.
- fifo_wren  out  1  queue write enable.
- fifo_din  out  LIT_W  queue write data.
- fifo_ren  out  1  queue read enable.
- fifo_dout  in  LIT_W  queue head.
- fifo_full  in  1  queue full flag.
- fifo_empty  in  1  queue empty flag.
- prop_valid  out  1  head literal valid to the propagation unit.
- prop_lit  out  LIT_W  head literal (= fifo_dout).
- prop_ready  in  1  propagation unit accepts the head.
- busy  out  1  high in FLUSH state.
- drop_cnt  out  CNT_W  literals discarded by flushes since reset; saturates.

Behaviour:
- Reset values (asynchronous): state=RUN, rr_ptr=0, drop_cnt=0, gnt=0, busy=0. fifo_wren, fifo_ren and prop_valid are combinational and read 0 whenever there is no request or the queue is empty.
- State machine, 2 states:
  - RUN→FLUSH when flush=1.
  - FLUSH→RUN when fifo_empty=1 and flush=0.
  - flush=1 while already in FLUSH keeps the block in FLUSH.
- RUN, write side:
  - If fifo_full=0 and flush=0, grant the first requester with req=1, searching from rr_ptr upward modulo NUM_REQ.
  - gnt, fifo_wren=|gnt and fifo_din are combinational in the same cycle; the queue captures the literal at the clock edge. Push latency is 0 cycles.
  - On a grant to i, rr_ptr ← (i+1) mod NUM_REQ. Otherwise rr_ptr holds.
  - fifo_full=1: gnt=0; requesters hold req and req_lit until granted.
- RUN, read side:
  - prop_valid = ~fifo_empty & ~flush.
  - fifo_ren = prop_valid & prop_ready.
  - prop_lit = fifo_dout unconditionally.
- Simultaneous push and pop: both are allowed in the same cycle, including when the queue is full. The full flag is evaluated before the pop, so no grant is made on a full queue even if a pop occurs that cycle.
- flush=1 in a RUN cycle: gnt=0, prop_valid=0, fifo_ren=0. The flush takes effect the next cycle.
- FLUSH:
  - gnt=0, prop_valid=0, busy=1.
  - fifo_ren = ~fifo_empty. drop_cnt increments by 1 per pop and saturates at 2^CNT_W-1.
  - An empty queue on entry means exactly 1 FLUSH cycle with no pops.
  - Maximum flush duration is 4 pops plus 1 exit cycle.
- Arithmetic: rr_ptr is a $clog2(NUM_REQ)-bit value; wrap is modulo NUM_REQ, which also covers non-power-of-2 NUM_REQ.
- Reset mid-flush: returns to RUN immediately with drop_cnt=0. The queue's own reset is the queue's responsibility.

Optional Feature:
- Macro: IMPL_DUP_FILTER_EN.
- Defined:
  - Register last_lit (LIT_W) and last_vld.
  - A granted literal equal to last_lit while last_vld=1 is acknowledged (gnt=1) but not written (fifo_wren=0).
  - On each actual write, last_lit ← fifo_din and last_vld ← 1.
  - last_vld clears on reset and on entry to FLUSH.
- Undefined: every grant writes; no extra registers.

Decomposition:
- Shared package impl_pkg holds:
  - LIT_W computation as a function of LITERALS.
  - state_t enum {ST_RUN, ST_FLUSH}.
  - QUEUE_DEPTH=4 constant.
- One sub-module, rr_arbiter. Inputs: req, rr_ptr. Output: one-hot gnt. It is purely combinational priority rotation; the pointer register stays in the parent.

Test Plan:
- Arbitration fairness: req=4'b1111 held with queue never full and prop_ready=1 → grants cycle 0,1,2,3,0 on consecutive cycles, with fifo_din equal to the matching req_lit slice.
- Backpressure: prop_ready=0, req[2]=1 with lit 4'h5 for 6 cycles → 4 writes, then gnt=0 while fifo_full=1. Raise prop_ready → head 4'h5 popped, then the next grant is to requester 2.
- Flush with data: 3 literals queued, flush pulsed 1 cycle → busy=1 for 4 cycles, fifo_ren=1 for 3 cycles, drop_cnt=3, prop_valid=0 throughout, gnt=0 even with req=4'b1111. RUN resumes afterwards.
- Flush on empty queue: flush pulse → busy=1 for 1 cycle, drop_cnt unchanged.
- Async reset asserted mid-FLUSH, between clock edges → busy, gnt, drop_cnt and rr_ptr return to 0 immediately, without waiting for a clock edge.
- IMPL_DUP_FILTER_EN defined: requester 0 pushes 4'h3 twice, then 4'h4 → 2 writes (3, 4) and 3 grants. With the macro undefined → 3 writes.
